// File: rtl/main_memory_responder.sv
// main_memory_responder
//
// Memory-side responder for two L1 data cache controllers. Word read/write
// requests from core 0 and core 1 are arbitrated round-robin and served one at
// a time from a local word array after LATENCY wait cycles. Each transaction
// ends with a one-cycle rvalid pulse on the port that was granted.
//
// Ports:
//   clk                  clock, all logic on the rising edge
//   reset                synchronous active-high reset
//   req0_i / req1_i      request, held high until that port's rvalid
//   we0_i / we1_i        1 = write, 0 = read
//   addr0_i / addr1_i    byte address, bits [1:0] ignored
//   wdata0_i / wdata1_i  write data
//   be0_i / be1_i        byte enables for writes
//   gnt0_o / gnt1_o      one-cycle pulse: request accepted
//   rvalid0_o/rvalid1_o  one-cycle pulse: transaction complete
//   rdata_o              shared read data, valid with either rvalid
//   busy_o               high whenever the responder is not idle

module main_memory_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [3:0]        be0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [3:0]        be1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  localparam int unsigned IdxW = ADDR_W - 2;
  localparam logic [3:0] CntInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q;
  logic              port_q;
  logic              we_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  logic gnt0, gnt1, grant;
  logic access_en;

  // Fields of the winning request, selected by the grant.
  logic              sel_we;
  logic [IdxW-1:0]   sel_idx;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_be;

  // Fields used by the access: with zero latency the access happens on the
  // grant edge itself, before the latched copies exist.
  logic              acc_we;
  logic [IdxW-1:0]   acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic [3:0]        acc_be;

  // Round-robin: on a tie the port that was not granted last wins.
  always_comb begin
    gnt0  = (state_q == StIdle) && req0_i && (!req1_i || last_grant_q);
    gnt1  = (state_q == StIdle) && req1_i && (!req0_i || !last_grant_q);
    grant = gnt0 | gnt1;
  end

  always_comb begin
    sel_we    = gnt1 ? we1_i : we0_i;
    sel_idx   = gnt1 ? addr1_i[ADDR_W-1:2] : addr0_i[ADDR_W-1:2];
    sel_wdata = gnt1 ? wdata1_i : wdata0_i;
    sel_be    = gnt1 ? be1_i : be0_i;
    if (state_q == StIdle) begin
      acc_we    = sel_we;
      acc_idx   = sel_idx;
      acc_wdata = sel_wdata;
      acc_be    = sel_be;
    end else begin
      acc_we    = we_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    access_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          if (LATENCY > 0) begin
            state_d = StWait;
            cnt_d   = CntInit;
          end else begin
            state_d   = StResp;
            access_en = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d   = StResp;
          access_en = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    gnt0_o    = gnt0;
    gnt1_o    = gnt1;
    rvalid0_o = (state_q == StResp) && !port_q;
    rvalid1_o = (state_q == StResp) && port_q;
    rdata_o   = rdata_q;
    busy_o    = (state_q != StIdle);
  end

  // Request latch, arbitration history, memory array and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= 4'd0;
      rdata_q      <= '0;
      for (int w = 0; w < int'(MEM_WORDS); w++) begin
        mem_q[w] <= '0;
      end
    end else begin
      if (grant) begin
        last_grant_q <= gnt1;
        port_q       <= gnt1;
        we_q         <= sel_we;
        idx_q        <= sel_idx;
        wdata_q      <= sel_wdata;
        be_q         <= sel_be;
      end
      if (access_en) begin
        if (acc_we) begin
          for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
              mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
          end
          rdata_q <= '0;
        end else begin
          rdata_q <= mem_q[acc_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  localparam int Lat = 2;

  logic        clk = 1'b0;
  logic        reset;

  // DUT with LATENCY = 2
  logic        req0, we0, req1, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [31:0] rdata;

  // DUT with LATENCY = 0
  logic        b_req0, b_we0, b_req1, b_we1;
  logic [9:0]  b_addr0, b_addr1;
  logic [31:0] b_wdata0, b_wdata1;
  logic [3:0]  b_be0, b_be1;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy;
  logic [31:0] b_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_memory_responder #(.ADDR_W(10), .DATA_W(32), .MEM_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0), .be0_i(be0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1), .be1_i(be1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .busy_o(busy)
  );

  main_memory_responder #(.ADDR_W(10), .DATA_W(32), .MEM_WORDS(256), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req0_i(b_req0), .we0_i(b_we0), .addr0_i(b_addr0), .wdata0_i(b_wdata0), .be0_i(b_be0),
    .req1_i(b_req1), .we1_i(b_we1), .addr1_i(b_addr1), .wdata1_i(b_wdata1), .be1_i(b_be1),
    .gnt0_o(b_gnt0), .gnt1_o(b_gnt1), .rvalid0_o(b_rvalid0), .rvalid1_o(b_rvalid1),
    .rdata_o(b_rdata), .busy_o(b_busy)
  );

  typedef struct {
    logic        core;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 DUT, checking grant, the exact
  // response cycle, read data and return to idle.
  task automatic do_txn(input vec_t v);
    int n;
    @(negedge clk);
    if (v.core) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; be1 = v.be;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; be0 = v.be;
    end
    #1;
    n = 0;
    while (!(v.core ? gnt1 : gnt0) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({v.name, "_gnt"}, 32'(v.core ? gnt1 : gnt0), 32'd1);
    for (int k = 0; k < Lat; k++) begin
      @(negedge clk);
      check({v.name, "_no_rvalid_wait"}, 32'({rvalid1, rvalid0}), 32'd0);
    end
    @(negedge clk);
    check({v.name, "_rvalid"}, 32'({rvalid1, rvalid0}), v.core ? 32'd2 : 32'd1);
    check({v.name, "_rdata"}, rdata, v.exp_rdata);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check({v.name, "_idle"}, 32'({busy, rvalid1, rvalid0}), 32'd0);
  endtask

  task automatic wait_rvalid(input logic core, input string name);
    int n = 0;
    while (!(core ? rvalid1 : rvalid0) && n < 20) begin
      @(negedge clk); n++;
    end
    check({name, "_rvalid"}, 32'(core ? rvalid1 : rvalid0), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 32'h0, "rd_after_reset"};
    vecs[1] = '{1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0, "wr_full"};
    vecs[2] = '{1'b0, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, "rd_full"};
    vecs[3] = '{1'b1, 1'b1, 10'h010, 32'h11223344, 4'b0101, 32'h0, "wr_be"};
    vecs[4] = '{1'b1, 1'b0, 10'h012, 32'h0, 4'hF, 32'hDE22BE44, "rd_be"};
    vecs[5] = '{1'b1, 1'b1, 10'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, "wr_top"};
    vecs[6] = '{1'b0, 1'b0, 10'h3FF, 32'h0, 4'h0, 32'hCAFEF00D, "rd_top_3ff"};
    vecs[7] = '{1'b0, 1'b0, 10'h014, 32'h0, 4'h0, 32'h0, "rd_neighbour"};

    {req0, we0, req1, we1} = '0;
    {addr0, addr1, wdata0, wdata1, be0, be1} = '0;
    {b_req0, b_we0, b_req1, b_we1} = '0;
    {b_addr0, b_addr1, b_wdata0, b_wdata1, b_be0, b_be1} = '0;

    // Reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_outs", 32'({gnt0, gnt1, rvalid0, rvalid1, busy}), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_outs_l0", 32'({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy}), 32'd0);

    // Tie from reset: core 0 wins, core 1 follows in the IDLE after rvalid0
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h100; wdata0 = 32'h0000AAAA; be0 = 4'hF;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h100;
    #1;
    check("tie1_gnt", 32'({gnt1, gnt0}), 32'd1);
    repeat (Lat + 1) @(negedge clk);
    check("tie1_rvalid0", 32'({rvalid1, rvalid0}), 32'd1);
    req0 = 1'b0;
    @(negedge clk); #1;
    check("tie1_gnt1_next", 32'({gnt1, gnt0}), 32'd2);
    repeat (Lat + 1) @(negedge clk);
    check("tie1_rvalid1", 32'({rvalid1, rvalid0}), 32'd2);
    check("tie1_rdata", rdata, 32'h0000AAAA);
    req1 = 1'b0;
    @(negedge clk);
    // Second tie: core 1 was last, so core 0 wins again
    req0 = 1'b1; we0 = 1'b0; req1 = 1'b1;
    #1;
    check("tie2_gnt", 32'({gnt1, gnt0}), 32'd1);
    @(negedge clk);
    wait_rvalid(1'b0, "tie2_core0");
    req0 = 1'b0;
    @(negedge clk); #1;
    check("tie2_gnt1_next", 32'({gnt1, gnt0}), 32'd2);
    @(negedge clk);
    wait_rvalid(1'b1, "tie2_core1");
    req1 = 1'b0;
    @(negedge clk);

    // Table-driven transactions
    foreach (vecs[i]) do_txn(vecs[i]);

    // Reset during the first WAIT cycle of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'h020; wdata0 = 32'h5A5A5A5A; be0 = 4'hF;
    #1;
    check("rst_mid_gnt", 32'(gnt0), 32'd1);
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    req0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_mid_no_rvalid", 32'({rvalid1, rvalid0, busy}), 32'd0);
    end
    reset = 1'b0;
    do_txn('{1'b0, 1'b0, 10'h020, 32'h0, 4'h0, 32'h0, "rd_discarded_wr"});
    do_txn('{1'b1, 1'b0, 10'h010, 32'h0, 4'h0, 32'h0, "rd_cleared"});

    // LATENCY=0 build: rvalid one cycle after grant, 0x3FF maps to word 255
    @(negedge clk);
    b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 10'h3FC; b_wdata0 = 32'h12345678; b_be0 = 4'hF;
    #1;
    check("l0_wr_gnt", 32'(b_gnt0), 32'd1);
    @(negedge clk);
    check("l0_wr_rvalid", 32'({b_rvalid1, b_rvalid0}), 32'd1);
    check("l0_wr_rdata", b_rdata, 32'd0);
    b_req0 = 1'b0;
    @(negedge clk);
    check("l0_idle", 32'(b_busy), 32'd0);
    b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 10'h3FF;
    #1;
    check("l0_rd_gnt", 32'({b_gnt1, b_gnt0}), 32'd2);
    @(negedge clk);
    check("l0_rd_rvalid", 32'({b_rvalid1, b_rvalid0}), 32'd2);
    check("l0_rd_rdata", b_rdata, 32'h12345678);
    b_req1 = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case something stalls beyond every bounded wait
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
